// File: rtl/fc_output_pack.sv
// Packs one frame of class scores from a serial byte stream into a wide result
// vector and tracks the winning class; malformed frames are dropped and flagged.
module fc_output_pack #(
  parameter int NUM_CLASSES   = 10,
  parameter bit SIGNED_SCORES = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic [7:0]               din,
  input  logic                     din_last,
  output logic [8*NUM_CLASSES-1:0] dout,
  output logic                     dout_valid,
  output logic [3:0]               class_idx,
  output logic                     frame_err
);

  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int DW = 8 * NUM_CLASSES;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [7:0]    max_val_q, max_val_d;
  logic [3:0]    max_idx_q, max_idx_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic [3:0]    class_idx_q, class_idx_d;
  logic          frame_err_q, frame_err_d;

  logic          last_slot;
  logic          din_greater;
  logic          take_new;
  logic [7:0]    beat_max_val;
  logic [3:0]    beat_max_idx;
  logic [DW-1:0] shadow_ins;

  // Running argmax including the current beat; strict compare keeps ties on the lowest index.
  always_comb begin
    last_slot = (cnt_q == CW'(NUM_CLASSES - 1));
    if (SIGNED_SCORES) begin
      din_greater = ($signed(din) > $signed(max_val_q));
    end else begin
      din_greater = (din > max_val_q);
    end
    take_new     = (cnt_q == '0) || din_greater;
    beat_max_val = take_new ? din : max_val_q;
    beat_max_idx = take_new ? 4'(cnt_q) : max_idx_q;

    shadow_ins = shadow_q;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt_q == CW'(i)) begin
        shadow_ins[8*(NUM_CLASSES-1-i) +: 8] = din;
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    class_idx_d  = class_idx_q;
    frame_err_d  = 1'b0;

    if (din_valid) begin
      if (din_last && last_slot) begin
        shadow_d     = shadow_ins;
        dout_d       = shadow_ins;
        class_idx_d  = beat_max_idx;
        dout_valid_d = 1'b1;
        cnt_d        = '0;
      end else if (din_last || last_slot) begin
        // Early or missing last: drop the partial frame, outputs keep the last good one.
        frame_err_d = 1'b1;
        cnt_d       = '0;
      end else begin
        shadow_d  = shadow_ins;
        max_val_d = beat_max_val;
        max_idx_d = beat_max_idx;
        cnt_d     = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shadow_q     <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      class_idx_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      class_idx_q  <= class_idx_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign class_idx  = class_idx_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fc_output_pack.sv
// Scoreboard bench for fc_output_pack: a frame-level reference model queues expected
// pulses; a monitor pops and compares them for a signed and an unsigned instance.
module tb_fc_output_pack;

  localparam int NC = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_valid;
  logic [7:0]    din;
  logic          din_last;
  logic [8*NC-1:0] dout, dout_u;
  logic          dout_valid, dout_valid_u;
  logic [3:0]    class_idx, class_idx_u;
  logic          frame_err, frame_err_u;

  fc_output_pack #(.NUM_CLASSES(NC), .SIGNED_SCORES(1'b1)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_last(din_last),
    .dout(dout), .dout_valid(dout_valid), .class_idx(class_idx), .frame_err(frame_err)
  );

  fc_output_pack #(.NUM_CLASSES(NC), .SIGNED_SCORES(1'b0)) dut_u (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_last(din_last),
    .dout(dout_u), .dout_valid(dout_valid_u), .class_idx(class_idx_u), .frame_err(frame_err_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [8*NC-1:0] dout;
    logic [3:0]    idx_s;
    logic [3:0]    idx_u;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] frame_q[$];
  logic [8*NC-1:0] last_good = '0;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [8*NC-1:0] act, input logic [8*NC-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [3:0] argmax(input bit signed_mode);
    int best = 0;
    int best_v = 0;
    for (int i = 0; i < NC; i++) begin
      int v = signed_mode ? int'($signed(frame_q[i])) : int'(frame_q[i]);
      if (i == 0 || v > best_v) begin
        best = i;
        best_v = v;
      end
    end
    return 4'(best);
  endfunction

  // Frame-level model: decides the frame outcome once its final beat is seen.
  task automatic model_beat(input logic [7:0] d, input logic l);
    exp_t e;
    frame_q.push_back(d);
    e.cyc = cyc + 1;
    if (l && frame_q.size() == NC) begin
      e.is_err = 1'b0;
      e.dout = '0;
      for (int i = 0; i < NC; i++) e.dout[8*(NC-1-i) +: 8] = frame_q[i];
      e.idx_s = argmax(1'b1);
      e.idx_u = argmax(1'b0);
      last_good = e.dout;
      exp_q.push_back(e);
      frame_q.delete();
    end else if (l || frame_q.size() == NC) begin
      e.is_err = 1'b1;
      e.dout = last_good;
      e.idx_s = 4'd0;
      e.idx_u = 4'd0;
      exp_q.push_back(e);
      frame_q.delete();
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    @(negedge clk);
    din_valid = 1'b1;
    din = d;
    din_last = l;
    model_beat(d, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din = $urandom_range(0, 255);
      din_last = $urandom_range(0, 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    din_last = 1'b0;
    frame_q.delete();
    last_good = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] s[NC], input int max_gap);
    for (int i = 0; i < NC; i++) begin
      beat(s[i], i == NC - 1);
      if (max_gap > 0 && i != NC - 1) idle($urandom_range(1, max_gap));
    end
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (dout_valid || frame_err || dout_valid_u || frame_err_u) begin
      check("exclusive", {79'd0, dout_valid & frame_err}, '0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {78'd0, dout_valid, frame_err}, '0);
      end else begin
        m = exp_q.pop_front();
        check("pulse_cycle", 80'(cyc), 80'(m.cyc));
        check("frame_err", {79'd0, frame_err}, {79'd0, m.is_err});
        check("dout_valid", {79'd0, dout_valid}, {79'd0, !m.is_err});
        check("frame_err_u", {79'd0, frame_err_u}, {79'd0, m.is_err});
        check("dout_valid_u", {79'd0, dout_valid_u}, {79'd0, !m.is_err});
        check("dout", dout, m.dout);
        check("dout_u", dout_u, m.dout);
        if (!m.is_err) begin
          check("class_idx", 80'(class_idx), 80'(m.idx_s));
          check("class_idx_u", 80'(class_idx_u), 80'(m.idx_u));
        end
      end
    end
  end

  logic [7:0] fa[NC] = '{8'h35, 8'h0f, 8'h4c, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h27, 8'h00};
  logic [7:0] fs[NC] = '{8'h80, 8'hf0, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] fr[NC];

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    din_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dout", dout, '0);
    check("rst_class_idx", 80'(class_idx), '0);
    check("rst_dout_valid", {79'd0, dout_valid}, '0);
    check("rst_frame_err", {79'd0, frame_err}, '0);

    send_frame(fa, 0);
    idle(3);
    check("frame_a_dout", dout, 80'h350f4c00000022002700);
    check("frame_a_idx", 80'(class_idx), 80'd2);

    send_frame(fa, 5);
    idle(3);
    send_frame(fs, 0);
    idle(3);

    for (int i = 0; i < 5; i++) beat(fr_byte(), i == 4);
    idle(2);
    send_frame(fa, 0);
    idle(2);

    for (int i = 0; i < NC; i++) beat(fr_byte(), 1'b0);
    idle(2);
    send_frame(fs, 2);
    idle(3);

    for (int i = 0; i < 6; i++) beat(fr_byte(), 1'b0);
    do_reset();
    check("mid_rst_dout", dout, '0);
    check("mid_rst_idx", 80'(class_idx), '0);
    check("mid_rst_dout_u", dout_u, '0);
    send_frame(fa, 0);

    for (int i = 0; i < NC; i++) fr[i] = fr_byte();
    send_frame(fr, 0);
    idle(2);

    for (int f = 0; f < 40; f++) begin
      int kind = $urandom_range(0, 7);
      bit narrow = ($urandom_range(0, 2) == 0);
      int len = (kind == 0) ? $urandom_range(1, NC - 1) : NC;
      for (int i = 0; i < len; i++) begin
        logic [7:0] b = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        beat(b, (kind == 1) ? 1'b0 : (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("pending_expectations", 80'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic [7:0] fr_byte();
    return 8'($urandom_range(0, 255));
  endfunction

endmodule
